imm_decode_stage: RTL
=====================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, output datapath width; legal values 32 and 64 only.
REQ-002 The block SHALL have parameter EXT_SEL, default 0; 0 means the immediate type is decoded from the opcode, 1 means it is taken from in_imm_sel.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port flush, input, 1, synchronous pipeline kill.
REQ-006 The block SHALL have port in_valid, input, 1, upstream holds a valid instruction.
REQ-007 The block SHALL have port in_ready, output, 1, block accepts input this cycle; registered.
REQ-008 The block SHALL have port in_instr, input, 32, full 32-bit instruction word.
REQ-009 The block SHALL have port in_pc, input, XLEN, PC of in_instr.
REQ-010 The block SHALL have port in_imm_sel, input, 3, external type select, used only when EXT_SEL=1.
REQ-011 The block SHALL have port out_valid, output, 1, output entry valid.
REQ-012 The block SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 The block SHALL have ports out_instr (32), out_pc (XLEN), out_imm (XLEN), out_imm_type (3) and out_illegal (1), all outputs, all registered.

Function
REQ-014 Type codes SHALL be: 000 U, 001 J, 010 S, 011 B, 100 I, 101 I-shift, 110 IU (zero-extended instr[31:20]), 111 NONE (imm=0).
REQ-015 Extraction SHALL follow standard RV fields on instr[31:0]; every type except IU and I-shift SHALL be sign-extended from instr[31] to XLEN.
REQ-016 I-shift SHALL zero-extend instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
REQ-017 With EXT_SEL=0, opcode decode SHALL map: 0110111/0010111 -> U; 1101111 -> J; 1100111, 0000011, 0001111 -> I; 1100011 -> B; 0100011 -> S; 0010011 -> I-shift if funct3 is 001 or 101, else I; 1110011 -> IU; 0110011 -> NONE.
REQ-018 With EXT_SEL=0, any other opcode SHALL give NONE with out_illegal=1; with EXT_SEL=1, out_illegal SHALL always be 0.
REQ-019 The immediate SHALL be computed on the input side and registered with its instruction; latency from acceptance to out_valid SHALL be 1 cycle.
REQ-020 Buffering SHALL be a 2-entry skid buffer (main register drives the outputs, plus a skid register) controlled by states EMPTY, ONE and TWO.
REQ-021 out_valid SHALL be 1 when the state is not EMPTY; in_ready SHALL be 1 when the state is not TWO.
REQ-022 Define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-023 From EMPTY, in_fire SHALL load main and go to ONE.
REQ-024 In ONE, in_fire & out_fire SHALL reload main and stay in ONE; in_fire & !out_fire SHALL load skid and go to TWO; !in_fire & out_fire SHALL go to EMPTY.
REQ-025 In TWO, out_fire SHALL move skid to main and go to ONE.
REQ-026 Ordering SHALL be strict FIFO with no loss or duplication under any valid/ready pattern.
REQ-027 flush SHALL force EMPTY on the next edge and drop any same-cycle in_fire; reset SHALL take priority over flush.
REQ-028 Outputs SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-029 On reset the state SHALL be EMPTY, out_valid=0, in_ready=1, and out_instr, out_pc, out_imm, out_imm_type and out_illegal SHALL all be 0.
REQ-030 Reset asserted mid-operation (state ONE or TWO) SHALL discard all entries at the next edge.

Structure
REQ-031 Package riscv_imm_pkg SHALL hold the imm_type_e enum (the 3-bit codes of REQ-014), the opcode constants and the skid-state enum.
REQ-032 Combinational extraction SHALL live in sub-module imm_extract (parameter XLEN; inputs instr and type; output imm); the top level holds decode, skid registers and the FSM.

Verification
REQ-033 XLEN=32, 0xFFF00093, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, type 100, illegal=0.
REQ-034 XLEN=32, 0xFE20AE23 (sw) -> out_imm=0xFFFFFFFC, type 010.
REQ-035 XLEN=64, 0x03F09093 (slli 63) -> out_imm=0x000000000000003F, type 101.
REQ-036 0x0000007F -> out_illegal=1, out_imm=0; 0x002081B3 -> type 111, out_imm=0, illegal=0.
REQ-037 out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 the cycle after the 2nd; then out_ready=1 -> both emitted in order, 3rd accepted once in_ready returns.
REQ-038 In TWO assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, nothing emitted; repeat with reset+flush -> all outputs 0.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// Shared definitions for the immediate decode stage.
// Holds the 3-bit immediate type codes, the RV base opcodes the decoder
// recognises, and the state encoding of the 2-entry output skid buffer.
package riscv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_U    = 3'b000,
    IMM_J    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_I    = 3'b100,
    IMM_ISH  = 3'b101,  // shift amount, zero-extended
    IMM_IU   = 3'b110,  // CSR address, zero-extended instr[31:20]
    IMM_NONE = 3'b111   // no immediate, value is 0
  } imm_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_TWO   = 2'b10
  } skid_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational RV immediate extraction.
// Ports:
//   instr    - 32-bit instruction word
//   imm_type - immediate format to extract
//   imm      - immediate widened to XLEN (sign- or zero-extended by type)
module imm_extract
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]            instr,
  input  imm_type_e              imm_type,
  output logic signed [XLEN-1:0] imm
);

  // Opcode bits carry no immediate information.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Widening from the 32-bit intermediate; zero-extended types already
  // have bit 31 clear, so a signed widen is correct for all of them.
  function automatic logic signed [XLEN-1:0] widen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic signed [31:0] v32;

  always_comb begin
    v32 = '0;
    case (imm_type)
      IMM_U:   v32 = {instr[31:12], 12'b0};
      IMM_J:   v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_S:   v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_I:   v32 = {{20{instr[31]}}, instr[31:20]};
      IMM_ISH: begin
        // RV64 shifts use a 6-bit shamt; on RV32 bit 25 belongs to funct7.
        if (XLEN == 64) v32 = {26'b0, instr[25:20]};
        else            v32 = {27'b0, instr[24:20]};
      end
      IMM_IU:  v32 = {20'b0, instr[31:20]};
      default: v32 = '0;
    endcase
    imm = widen(v32);
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage with a 2-entry skid buffer.
// Decodes the immediate type (from the opcode, or from in_imm_sel when
// EXT_SEL=1), extracts the immediate on the input side, and registers it
// together with the instruction and PC.
// Ports:
//   clk, reset (sync, active-high), flush (sync pipeline kill)
//   in_valid/in_ready/in_instr/in_pc/in_imm_sel - upstream handshake + data
//   out_valid/out_ready                          - downstream handshake
//   out_instr/out_pc/out_imm/out_imm_type/out_illegal - registered outputs
module imm_decode_stage
  import riscv_imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EXT_SEL = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  // ---- Stage p0: combinational decode and extraction ----
  imm_type_e              type_p0;
  logic                   illegal_p0;
  logic signed [XLEN-1:0] imm_p0;

  always_comb begin
    type_p0    = IMM_NONE;
    illegal_p0 = 1'b0;
    if (EXT_SEL != 0) begin
      type_p0 = imm_type_e'(in_imm_sel);
    end else begin
      case (in_instr[6:0])
        OP_LUI, OP_AUIPC:            type_p0 = IMM_U;
        OP_JAL:                      type_p0 = IMM_J;
        OP_JALR, OP_LOAD, OP_FENCE:  type_p0 = IMM_I;
        OP_BRANCH:                   type_p0 = IMM_B;
        OP_STORE:                    type_p0 = IMM_S;
        OP_OPIMM: begin
          if (in_instr[14:12] == F3_SLL || in_instr[14:12] == F3_SRX)
            type_p0 = IMM_ISH;
          else
            type_p0 = IMM_I;
        end
        OP_SYSTEM:                   type_p0 = IMM_IU;
        OP_OP:                       type_p0 = IMM_NONE;
        default: begin
          type_p0    = IMM_NONE;
          illegal_p0 = 1'b1;
        end
      endcase
    end
  end

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr    (in_instr),
    .imm_type (type_p0),
    .imm      (imm_p0)
  );

  // ---- Stage p1: main (output) register, skid register and control ----
  skid_state_e            state;
  logic [31:0]            skid_instr_p1;
  logic [XLEN-1:0]        skid_pc_p1;
  logic signed [XLEN-1:0] skid_imm_p1;
  imm_type_e              skid_type_p1;
  logic                   skid_illegal_p1;

  logic in_fire;
  logic out_fire;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SKID_EMPTY;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      out_instr    <= '0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_imm_type <= 3'b000;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      // Same-cycle in_fire is dropped: nothing is loaded.
      state     <= SKID_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_fire) begin
            out_instr    <= in_instr;
            out_pc       <= in_pc;
            out_imm      <= imm_p0;
            out_imm_type <= type_p0;
            out_illegal  <= illegal_p0;
            state        <= SKID_ONE;
            out_valid    <= 1'b1;
          end
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            out_instr    <= in_instr;
            out_pc       <= in_pc;
            out_imm      <= imm_p0;
            out_imm_type <= type_p0;
            out_illegal  <= illegal_p0;
          end else if (in_fire) begin
            // New entry parks in skid; main keeps the stalled output.
            state    <= SKID_TWO;
            in_ready <= 1'b0;
          end else if (out_fire) begin
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
          end
        end
        SKID_TWO: begin
          if (out_fire) begin
            out_instr    <= skid_instr_p1;
            out_pc       <= skid_pc_p1;
            out_imm      <= skid_imm_p1;
            out_imm_type <= skid_type_p1;
            out_illegal  <= skid_illegal_p1;
            state        <= SKID_ONE;
            in_ready     <= 1'b1;
          end
        end
        default: begin
          state     <= SKID_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Skid contents are only meaningful in TWO, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush && state == SKID_ONE && in_fire && !out_fire) begin
      skid_instr_p1   <= in_instr;
      skid_pc_p1      <= in_pc;
      skid_imm_p1     <= imm_p0;
      skid_type_p1    <= type_p0;
      skid_illegal_p1 <= illegal_p0;
    end
  end

endmodule
